// File: rtl/alu_pkg.sv
// alu_pkg: opcode values and FSM state encoding shared by the alu_seq block
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one multiplier bit per cycle, low WIDTH bits of product
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand, mplier, acc, acc_n;
  logic [CW-1:0]    cnt;
  logic             run;
  // done and p describe the final iteration so the owner can register p on that same edge
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  assign done  = run & (cnt == CW'(WIDTH - 1));
  assign p     = acc_n;
  // start latches operands; each running cycle consumes one multiplier bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      run    <= ~done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshake; ALU_MUL_EN enables the multi-cycle MUL
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);
  state_t           state, state_n;
  logic             acc_in, is_mul, mul_done, alu_c, alu_v, alu_e;
  logic [WIDTH-1:0] bx, alu_r, mul_p;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign acc_in    = in_valid & in_ready;
  assign shamt     = b[SHW-1:0];
`ifdef ALU_MUL_EN
  assign is_mul = op == OP_MUL;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (acc_in & is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p     (mul_p)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_p    = '0;
`endif
  // single-cycle datapath; SUB shares the adder as a + ~b + 1, unknown opcodes flag err
  always_comb begin
    bx    = (op == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, op == OP_SUB};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (op)
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      OP_NOR:  alu_r = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  alu_r = a << shamt;
      OP_SRL:  alu_r = a >> shamt;
      OP_SRA:  alu_r = $signed(a) >>> shamt;
      default: alu_e = 1'b1;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end
  // next state: accept in IDLE, iterate in BUSY, hold in DONE until consumed
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = acc_in ? (is_mul ? S_BUSY : S_DONE) : S_IDLE;
      S_BUSY:  state_n = mul_done ? S_DONE : S_BUSY;
      S_DONE:  state_n = out_ready ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // result and flags load on a single-cycle accept or on multiplier completion, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else if (acc_in & is_mul) begin
      err      <= 1'b0;
    end else if (acc_in) begin
      result   <= alu_r;
      zero     <= alu_r == '0;
      carry    <= alu_c;
      overflow <= alu_v;
      err      <= alu_e;
    end else if (state == S_BUSY && mul_done) begin
      result   <= mul_p;
      zero     <= mul_p == '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU for the MyALU datapath. It generalises the single-function 32-bit combinational units into one WIDTH-bit block with an opcode, status flags and a valid/ready handshake on both sides. All logic, arithmetic, compare and shift ops complete in one cycle. An optional shift-add multiplier takes WIDTH cycles. The CPU datapath and the board test harness drive it through the handshake.

## Interface
- WIDTH, 32: operand and result width; ≥ 4, power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand/op offer.
- in_ready  out  1  block can accept; reset 1.
- op  in  4  operation code.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shifts use b[SHW-1:0].
- out_valid  out  1  result available; reset 0.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result; reset 0.
- zero  out  1  result == 0; reset 0.
- carry  out  1  carry-out for ADD/SUB, else 0; reset 0.
- overflow  out  1  signed overflow for ADD/SUB, else 0; reset 0.
- err  out  1  illegal opcode; reset 0.

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NOR.
  - 4 ADD, 5 SUB.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, A SRA.
  - B MUL (low WIDTH bits of product).
  - C–F illegal.
- SUB is computed as a + ~b + 1; carry = carry-out of that sum (1 = no borrow).
- overflow = operand signs agree (after the b-inversion for SUB) and result sign differs.
- SLT/SLTU return 1 or 0, zero-extended.
- Illegal op: result 0, err 1, zero 1, single-cycle.
- FSM states:
  - IDLE: in_ready = 1. A transfer (in_valid & in_ready) of a single-cycle op registers all outputs and moves to DONE. A MUL transfer latches operands and moves to BUSY.
  - BUSY: one multiplier bit per cycle. After WIDTH iterations, registers the result and moves to DONE.
  - DONE: out_valid = 1. result and flags hold stable until out_ready. On out_ready, moves to IDLE.
- in_ready is 0 in BUSY and DONE. Inputs offered then are ignored.
- err clears on the next accepted op.

## Timing
- Single-cycle op accepted at edge N: out_valid high after edge N+1.
- MUL accepted at edge N: out_valid high after edge N+WIDTH+1.
- out_valid is held indefinitely under backpressure; outputs do not change.
- A result is consumed at the same edge out_ready is sampled high. in_ready rises the following cycle. Peak throughput is one op per 2 cycles.
- in_valid may drop without acceptance; no state change results.
- rst at any time, including mid-MUL or mid-DONE:
  - State returns to IDLE and the partial product is discarded.
  - All outputs return to their reset values immediately.

## Configuration
- ALU_MUL_EN defined: opcode B runs the multi-cycle multiplier and BUSY exists.
- ALU_MUL_EN undefined:
  - Opcode B is illegal (err 1, 1-cycle) and BUSY is unreachable.
  - No multiplier registers are synthesised.

## Structure
- Package alu_pkg:
  - Opcode localparams (OP_AND … OP_MUL).
  - FSM state encoding (S_IDLE, S_BUSY, S_DONE).
- Sub-module alu_mul_seq holds the shift-add multiplier: WIDTH-bit multiplicand, multiplier shift register, accumulator, iteration counter.
  - Interface: start, a, b, done, p.
  - It is instantiated only under ALU_MUL_EN.
- Single-cycle datapath and FSM stay in alu_seq.

## Test plan
All with WIDTH=32.
- AND 0xF0F0F0F0, 0xFF00FF00 → result 0xF000F000, zero 0, out_valid exactly one cycle after accept.
- ADD 0x7FFFFFFF+0x1 → 0x80000000, overflow 1, carry 0. SUB 5−5 → 0, zero 1, carry 1, overflow 0.
- Shifts and compares:
  - SRA 0x80000000 with b=0x24 → 0xF8000000 (shamt 4).
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SLTU same operands → 0.
- MUL 0x10000×0x10001 → 0x00010000, out_valid 33 cycles after accept.
  - Then hold out_ready low 5 cycles: result stable, in_ready 0.
  - A second in_valid offer during that window is ignored.
- Reset and illegal op:
  - rst asserted 10 cycles into MUL → out_valid 0, result 0, in_ready 1 after release.
  - op 0xF → err 1, result 0, zero 1, latency 1.
  - Without ALU_MUL_EN, op 0xB behaves identically.
